// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU serial command protocol: FSM states,
// packet/frame geometry and the 11-bit packet builder.
package alu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } serializer_state_t;

    localparam int   PKT_BITS      = 11;
    localparam int   FRAME_BITS    = 99;
    localparam logic PKT_TYPE_DATA = 1'b0;
    localparam logic PKT_TYPE_CTL  = 1'b1;

    // Start bit, type bit, payload MSB first, stop bit; bit 10 goes on the line first.
    function automatic logic [PKT_BITS-1:0] build_packet(input logic ptype, input logic [7:0] pbyte);
        return {1'b0, ptype, pbyte, 1'b1};
    endfunction

endpackage

// File: rtl/alu_crc4_d68.sv
// Combinational CRC-4 (x^4+x+1, init 0) over a 68-bit word, data[67] processed first.
// Kept standalone so RTL-side checkers can reuse the same generator.
module alu_crc4_d68 (
    input  logic [67:0] data,
    output logic [3:0]  crc
);

    function automatic logic [3:0] crc4_d68(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c  = 4'b0000;
        fb = 1'b0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    assign crc = crc4_d68(data);

endmodule

// File: rtl/alu_cmd_serializer.sv
// Serial transmitter for ALU commands: accepts (A, B, op) on valid/ready and shifts out the
// 99-bit frame on sin. Optional fault injection (CRC invert, A[7:0] drop) under ALU_SER_ERR_INJECT_EN.
module alu_cmd_serializer
    import alu_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic signed [31:0] cmd_a,
    input  logic signed [31:0] cmd_b,
    input  logic [2:0]         cmd_op,
`ifdef ALU_SER_ERR_INJECT_EN
    input  logic               cmd_inj_crc,
    input  logic               cmd_inj_drop,
`endif
    output logic               sin,
    output logic               busy,
    output logic               done
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    serializer_state_t     state;
    logic [FRAME_BITS-1:0] shreg;
    logic [6:0]            bit_cnt;
    logic [3:0]            gap_cnt;
    logic                  ready_q;

    logic [67:0]             crc_data;
    logic [3:0]              crc_calc;
    logic [3:0]              crc_tx;
    logic [7*PKT_BITS-1:0]   head_pkts;
    logic [PKT_BITS-1:0]     a0_pkt;
    logic [PKT_BITS-1:0]     ctl_pkt;
    logic [FRAME_BITS-1:0]   frame_next;
    logic [6:0]              bit_cnt_init;

    assign crc_data  = {cmd_b, cmd_a, 1'b1, cmd_op};
    assign cmd_ready = ready_q && !rst;

    alu_crc4_d68 u_crc (
        .data (crc_data),
        .crc  (crc_calc)
    );

    // Whole frame is assembled from the live inputs and captured on the accept edge.
    always_comb begin
        crc_tx = crc_calc;
`ifdef ALU_SER_ERR_INJECT_EN
        if (cmd_inj_crc) crc_tx = ~crc_calc;
`endif
        head_pkts = {build_packet(PKT_TYPE_DATA, cmd_b[31:24]),
                     build_packet(PKT_TYPE_DATA, cmd_b[23:16]),
                     build_packet(PKT_TYPE_DATA, cmd_b[15:8]),
                     build_packet(PKT_TYPE_DATA, cmd_b[7:0]),
                     build_packet(PKT_TYPE_DATA, cmd_a[31:24]),
                     build_packet(PKT_TYPE_DATA, cmd_a[23:16]),
                     build_packet(PKT_TYPE_DATA, cmd_a[15:8])};
        a0_pkt       = build_packet(PKT_TYPE_DATA, cmd_a[7:0]);
        ctl_pkt      = build_packet(PKT_TYPE_CTL, {1'b0, cmd_op, crc_tx});
        frame_next   = {head_pkts, a0_pkt, ctl_pkt};
        bit_cnt_init = 7'(FRAME_BITS - 1);
`ifdef ALU_SER_ERR_INJECT_EN
        if (cmd_inj_drop) begin
            frame_next   = {{PKT_BITS{1'b0}}, head_pkts, ctl_pkt};
            bit_cnt_init = 7'(FRAME_BITS - PKT_BITS - 1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            sin     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
            gap_cnt <= '0;
            ready_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    sin     <= 1'b1;
                    ready_q <= 1'b1;
                    if (cmd_valid && ready_q) begin
                        shreg   <= frame_next;
                        bit_cnt <= bit_cnt_init;
                        busy    <= 1'b1;
                        ready_q <= 1'b0;
                        state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    sin <= shreg[bit_cnt];
                    if (bit_cnt == 7'd0) begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else begin
                        bit_cnt <= bit_cnt - 7'd1;
                    end
                end
                S_GAP: begin
                    // First gap cycle is the one right after the stop bit was on the line.
                    sin  <= 1'b1;
                    done <= (gap_cnt == 4'd0);
                    if (gap_cnt == GAP_LAST) begin
                        busy    <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_serializer.sv
// Directed bench for alu_cmd_serializer: frame contents with hand-computed CRCs,
// timing of start/done/ready, back-to-back spacing and mid-frame reset.
module tb_alu_cmd_serializer;

    localparam int GAP = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic signed [31:0] cmd_a;
    logic signed [31:0] cmd_b;
    logic [2:0]         cmd_op;
    logic               sin;
    logic               busy;
    logic               done;
`ifdef ALU_SER_ERR_INJECT_EN
    logic               inj_crc  = 1'b0;
    logic               inj_drop = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_cmd_serializer #(.GAP_CYCLES(GAP)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_op       (cmd_op),
`ifdef ALU_SER_ERR_INJECT_EN
        .cmd_inj_crc  (inj_crc),
        .cmd_inj_drop (inj_drop),
`endif
        .sin          (sin),
        .busy         (busy),
        .done         (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [98:0] obs, input logic [98:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] pkt(input logic t, input logic [7:0] b);
        return {1'b0, t, b, 1'b1};
    endfunction

    function automatic logic [98:0] frame(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic [3:0] crc);
        return {pkt(1'b0, b[31:24]), pkt(1'b0, b[23:16]), pkt(1'b0, b[15:8]), pkt(1'b0, b[7:0]),
                pkt(1'b0, a[31:24]), pkt(1'b0, a[23:16]), pkt(1'b0, a[15:8]), pkt(1'b0, a[7:0]),
                pkt(1'b1, {1'b0, op, crc})};
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check(tag, cmd_ready, 1'b1);
    endtask

    task automatic send_frame(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] op, input logic [3:0] crc);
        logic [98:0] exp;
        logic [98:0] cap;
        exp = frame(a, b, op, crc);
        wait_ready({tag, "_ready"});
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        tick();
        // Scramble the inputs right after accept; the frame must not change.
        cmd_valid = 1'b0; cmd_a = 32'h5A5A_A5A5; cmd_b = 32'hA5A5_5A5A; cmd_op = 3'b111;
        check({tag, "_ready_low"}, cmd_ready, 1'b0);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_idle_before_start"}, sin, 1'b1);
        cap = '0;
        for (int k = 0; k < 99; k++) begin
            tick();
            cap = {cap[97:0], sin};
        end
        for (int p = 0; p < 9; p++)
            check($sformatf("%s_pkt%0d", tag, p), cap[98-11*p -: 11], exp[98-11*p -: 11]);
        check({tag, "_done_early"}, done, 1'b0);
        tick();
        check({tag, "_done_pulse"}, done, 1'b1);
        check({tag, "_gap_sin"}, sin, 1'b1);
        check({tag, "_ready_in_gap"}, cmd_ready, 1'b0);
        tick();
        check({tag, "_done_width"}, done, 1'b0);
        check({tag, "_ready_after_gap"}, cmd_ready, 1'b1);
        check({tag, "_busy_after_gap"}, busy, 1'b0);
    endtask

    int          first_start;
    int          second_start;
    int          early_ready;
    int          done_cnt;
    int          bad_sin;
    logic        will_accept;
    logic [98:0] cap1;
    logic [98:0] cap2;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        repeat (3) tick();
        check("reset_sin", sin, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_ready", cmd_ready, 1'b0);
        rst = 1'b0;
        tick();
        check("ready_after_reset", cmd_ready, 1'b1);

        // Hand-derived CRCs: zeros -> B, A=1 -> E, op=7 -> 2, B=8000_0000 -> 5.
        send_frame("zero", 32'h0, 32'h0, 3'b000, 4'hB);
        send_frame("a_one", 32'h1, 32'h0, 3'b000, 4'hE);
        send_frame("op_ill", 32'h0, 32'h0, 3'b111, 4'h2);
        send_frame("b_neg", 32'h0, 32'h8000_0000, 3'b000, 4'h5);

        // Back-to-back: valid held high across two commands.
        wait_ready("b2b_ready");
        cmd_a = 32'h0; cmd_b = 32'h0; cmd_op = 3'b101; cmd_valid = 1'b1;
        tick();
        cmd_a = 32'h1; cmd_b = 32'h0; cmd_op = 3'b000;
        first_start = -1; second_start = -1; early_ready = 0; done_cnt = 0;
        cap1 = '0; cap2 = '0;
        for (int k = 1; k <= 205; k++) begin
            will_accept = cmd_ready && cmd_valid;
            tick();
            if (will_accept) cmd_valid = 1'b0;
            if (sin === 1'b0 && first_start < 0) first_start = k;
            else if (sin === 1'b0 && first_start >= 0 && k > first_start + 98 && second_start < 0)
                second_start = k;
            if (k <= 99) cap1 = {cap1[97:0], sin};
            if (second_start >= 0 && k < second_start + 99) cap2 = {cap2[97:0], sin};
            if (cmd_ready === 1'b1 && k < 99 + GAP) early_ready++;
            if (done === 1'b1) done_cnt++;
        end
        check("b2b_first_start", first_start, 1);
        check("b2b_spacing", second_start - first_start, 99 + GAP + 1);
        check("b2b_ready_between", early_ready, 0);
        check("b2b_frame1", cap1, frame(32'h0, 32'h0, 3'b101, 4'h4));
        check("b2b_frame2", cap2, frame(32'h1, 32'h0, 3'b000, 4'hE));
        check("b2b_done_count", done_cnt, 2);

        // Reset in the middle of a frame.
        wait_ready("rst_mid_ready");
        cmd_a = 32'h0; cmd_b = 32'h0; cmd_op = 3'b000; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (40) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_sin", sin, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_ready", cmd_ready, 1'b0);
        rst = 1'b0;
        tick();
        check("rst_mid_ready_after", cmd_ready, 1'b1);
        bad_sin = 0;
        repeat (10) begin
            tick();
            if (sin !== 1'b1) bad_sin++;
        end
        check("rst_mid_sin_stays_high", bad_sin, 0);
        send_frame("post_rst", 32'h1, 32'h0, 3'b000, 4'hE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
